// File: rtl/fetch_queue_if.sv
// fetch_queue_if -- handshake bundle between fetch, the fetch queue and decode.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high; valid never waits on ready, and the
// payload is only meaningful while valid is high.
//
// Signals:
//   in_valid / in_ready / in_addr / in_instr     fetch -> queue stream
//   out_valid / out_ready / out_addr / out_instr queue -> decode stream
//
// Modports:
//   slave  : the queue's view (consumes the in_* stream, produces out_*)
//   master : the surrounding pipeline's view (fetch + decode)
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_addr;
  logic [XLEN-1:0] in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_addr;
  logic [XLEN-1:0] out_instr;

  modport slave (
    input  in_valid, in_addr, in_instr, out_ready,
    output in_ready, out_valid, out_addr, out_instr
  );

  modport master (
    output in_valid, in_addr, in_instr, out_ready,
    input  in_ready, out_valid, out_addr, out_instr
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- instruction fetch queue (FIFO of {address, instruction}).
//
// Entries pushed by fetch leave towards decode in push order. A push in cycle
// N is visible at the head in cycle N+1. flush drops every entry (redirect);
// reset has priority over flush, flush over push/pop.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   When defined, an empty queue forwards the offered entry combinationally
//   to decode; if decode takes it in the same cycle it is never stored.
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   flush  in   discard all entries
//   bus    slave modport of fetch_queue_if (in_* / out_* handshakes)
//   count  out  number of stored entries
module fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  fetch_queue_if.slave               bus,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [XLEN-1:0] r_addr_mem  [DEPTH];
  logic [XLEN-1:0] r_instr_mem [DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_bypass_take;
  logic w_store;
  logic w_unload;

  assign w_empty = (r_count == '0);
  // Full means no push this cycle, even if a pop happens alongside it.
  assign w_full  = (r_count == DEPTH_C);

  assign bus.in_ready = !flush && !w_full;

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue: the offered entry is the head as seen by decode.
  assign bus.out_valid = !flush && (w_empty ? bus.in_valid : 1'b1);
  assign bus.out_addr  = (!flush && w_empty) ? bus.in_addr  : r_addr_mem[r_rd_ptr];
  assign bus.out_instr = (!flush && w_empty) ? bus.in_instr : r_instr_mem[r_rd_ptr];
  // Entry consumed straight through: neither storage nor pointers move.
  assign w_bypass_take = !flush && w_empty && bus.in_valid && bus.out_ready;
`else
  assign bus.out_valid = !flush && !w_empty;
  assign bus.out_addr  = r_addr_mem[r_rd_ptr];
  assign bus.out_instr = r_instr_mem[r_rd_ptr];
  assign w_bypass_take = 1'b0;
`endif

  assign w_push   = bus.in_valid  && bus.in_ready;
  assign w_pop    = bus.out_valid && bus.out_ready;
  assign w_store  = w_push && !w_bypass_take;
  assign w_unload = w_pop  && !w_bypass_take;

  assign count = r_count;

  // Pointers are PW bits wide, so +1 wraps DEPTH-1 -> 0 (DEPTH is a power of two).
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_unload) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_store, w_unload})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is written only on a real stored push; never cleared.
  always_ff @(posedge clock) begin
    if (!reset && !flush && w_store) begin
      r_addr_mem[r_wr_ptr]  <= bus.in_addr;
      r_instr_mem[r_wr_ptr] <= bus.in_instr;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue -- directed, table-driven bench for fetch_queue (XLEN=32,
// DEPTH=4). Honors FETCH_QUEUE_BYPASS_EN when compiled with it defined.
module tb_fetch_queue;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [2:0] count;

  always #5 clock = ~clock;

  fetch_queue_if #(.XLEN(32)) bus ();

  fetch_queue #(.XLEN(32), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    bit          fl;
    bit          iv;
    logic [31:0] addr;
    logic [31:0] instr;
    bit          ordy;
    bit          e_ir;
    bit          e_ov;
    bit          chk_d;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    int          e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(bit rst, bit fl, bit iv, logic [31:0] addr, logic [31:0] instr,
                            bit ordy, bit e_ir, bit e_ov, bit chk_d,
                            logic [31:0] e_addr, logic [31:0] e_instr, int e_cnt);
    vec_t t;
    t = '{rst, fl, iv, addr, instr, ordy, e_ir, e_ov, chk_d, e_addr, e_instr, e_cnt};
    vecs.push_back(t);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit fl, input bit iv,
                       input logic [31:0] addr, input logic [31:0] instr, input bit ordy);
    @(negedge clock);
    reset         = rst;
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_addr   = addr;
    bus.in_instr  = instr;
    bus.out_ready = ordy;
    #2;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;

    //  rst fl iv addr    instr   ordy | ir  ov    chk   e_addr  e_instr e_cnt
    // Reset held; then four pushes with decode stalled, then drain.
    v(1, 0, 0, 32'h0,   32'h0,  0,    1, 0,    0,    32'h0,  32'h0,  0);
    v(0, 0, 1, 32'h0,   32'h11, 0,    1, BYP,  BYP,  32'h0,  32'h11, 0);
    v(0, 0, 1, 32'h4,   32'h12, 0,    1, 1,    1,    32'h0,  32'h11, 1);
    v(0, 0, 1, 32'h8,   32'h13, 0,    1, 1,    1,    32'h0,  32'h11, 2);
    v(0, 0, 1, 32'hC,   32'h14, 0,    1, 1,    1,    32'h0,  32'h11, 3);
    v(0, 0, 0, 32'h0,   32'h0,  0,    0, 1,    1,    32'h0,  32'h11, 4);
    // Full + push offered + pop: only the pop happens.
    v(0, 0, 1, 32'h100, 32'h99, 1,    0, 1,    1,    32'h0,  32'h11, 4);
    v(0, 0, 0, 32'h0,   32'h0,  1,    1, 1,    1,    32'h4,  32'h12, 3);
    v(0, 0, 0, 32'h0,   32'h0,  1,    1, 1,    1,    32'h8,  32'h13, 2);
    v(0, 0, 0, 32'h0,   32'h0,  1,    1, 1,    1,    32'hC,  32'h14, 1);
    v(0, 0, 0, 32'h0,   32'h0,  0,    1, 0,    0,    32'h0,  32'h0,  0);
    // Fill three, then flush with push and pop requested.
    v(0, 0, 1, 32'h50,  32'h51, 0,    1, BYP,  BYP,  32'h50, 32'h51, 0);
    v(0, 0, 1, 32'h54,  32'h55, 0,    1, 1,    1,    32'h50, 32'h51, 1);
    v(0, 0, 1, 32'h58,  32'h59, 0,    1, 1,    1,    32'h50, 32'h51, 2);
    v(0, 1, 1, 32'h5C,  32'h5D, 1,    0, 0,    0,    32'h0,  32'h0,  3);
    v(0, 0, 0, 32'h0,   32'h0,  1,    1, 0,    0,    32'h0,  32'h0,  0);
    // Two stored, reset with a push pending: everything lost.
    v(0, 0, 1, 32'h60,  32'h61, 0,    1, BYP,  BYP,  32'h60, 32'h61, 0);
    v(0, 0, 1, 32'h64,  32'h65, 0,    1, 1,    1,    32'h60, 32'h61, 1);
    v(1, 0, 1, 32'h68,  32'h69, 0,    1, 1,    1,    32'h60, 32'h61, 2);
    v(0, 0, 0, 32'h0,   32'h0,  1,    1, 0,    0,    32'h0,  32'h0,  0);
    v(0, 0, 0, 32'h0,   32'h0,  1,    1, 0,    0,    32'h0,  32'h0,  0);
    // Empty queue, push and pop offered together (bypass vs. stored).
    v(0, 0, 1, 32'h40,  32'h41, 1,    1, BYP,  BYP,  32'h40, 32'h41, 0);
    v(0, 0, 0, 32'h0,   32'h0,  0,    1, !BYP, !BYP, 32'h40, 32'h41, BYP ? 0 : 1);
    v(0, 0, 0, 32'h0,   32'h0,  1,    1, !BYP, !BYP, 32'h40, 32'h41, BYP ? 0 : 1);
    v(0, 0, 0, 32'h0,   32'h0,  0,    1, 0,    0,    32'h0,  32'h0,  0);

    // Reset held across two edges before the table starts.
    repeat (2) @(posedge clock);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].addr, vecs[i].instr, vecs[i].ordy);
      check($sformatf("v%0d in_ready", i),  32'(bus.in_ready),  32'(vecs[i].e_ir));
      check($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      check($sformatf("v%0d count", i),     32'(count),         32'(vecs[i].e_cnt));
      if (vecs[i].chk_d) begin
        check($sformatf("v%0d out_addr", i),  bus.out_addr,  vecs[i].e_addr);
        check($sformatf("v%0d out_instr", i), bus.out_instr, vecs[i].e_instr);
      end
    end

    // ---- two stored entries, then 10 simultaneous push/pop (pointer wrap) ----
    drive(0, 0, 1, 32'h200, ~32'h200, 0);
    exp_q.push_back(32'h200);
    drive(0, 0, 1, 32'h204, ~32'h204, 0);
    exp_q.push_back(32'h204);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      a = 32'h20 + 32'(i) * 32'h4;
      drive(0, 0, 1, a, ~a, 1);
      check($sformatf("wrap%0d count", i),     32'(count),        32'd2);
      check($sformatf("wrap%0d in_ready", i),  32'(bus.in_ready), 32'd1);
      check($sformatf("wrap%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("wrap%0d out_addr", i),  bus.out_addr,      exp_q[0]);
      check($sformatf("wrap%0d out_instr", i), bus.out_instr,     ~exp_q[0]);
      void'(exp_q.pop_front());
      exp_q.push_back(a);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 32'h0, 32'h0, 1);
      check($sformatf("drain%0d count", i),    32'(count),    32'(2 - i));
      check($sformatf("drain%0d out_addr", i), bus.out_addr, exp_q[0]);
      void'(exp_q.pop_front());
    end
    drive(0, 0, 0, 32'h0, 32'h0, 0);
    check("final count",     32'(count),         32'd0);
    check("final out_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: width of instruction word and instruction address.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries; power of two, >= 2.
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  discard all entries (branch/jump redirect).
REQ-006 SHALL have port in_valid  input  1  fetch stage offers an entry.
REQ-007 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-008 SHALL have port in_addr  input  XLEN  instruction address of offered entry.
REQ-009 SHALL have port in_instr  input  XLEN  instruction word of offered entry.
REQ-010 SHALL have port out_valid  output  1  head entry available to decode.
REQ-011 SHALL have port out_ready  input  1  decode consumes head this cycle (low = stall).
REQ-012 SHALL have port out_addr  output  XLEN  address of head entry.
REQ-013 SHALL have port out_instr  output  XLEN  instruction word of head entry.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  number of stored entries.

Function
REQ-015 SHALL be a FIFO; push = in_valid && in_ready, pop = out_valid && out_ready; entries leave in push order.
REQ-016 SHALL drive in_ready = !flush && (count < DEPTH); a full queue SHALL NOT accept a push even if a pop occurs that cycle.
REQ-017 SHALL drive out_valid = !flush && (count != 0) (without REQ-031 feature); out_addr/out_instr SHALL come from the head storage entry.
REQ-018 SHALL make an entry pushed in cycle N visible at the outputs in cycle N+1 (one-cycle latency).
REQ-019 SHALL update count as count + push - pop each cycle; simultaneous push and pop leave count unchanged.
REQ-020 SHALL keep read and write pointers as $clog2(DEPTH)-bit counters that wrap from DEPTH-1 to 0.
REQ-021 SHALL hold out_addr/out_instr stable while out_valid && !out_ready.
REQ-022 SHALL, on flush, set count and both pointers to 0 on the next edge; a concurrent push or pop SHALL be ignored.
REQ-023 SHALL give reset priority over flush, and flush priority over push/pop.
REQ-024 SHALL NOT modify storage contents when no push occurs; storage contents need not be cleared by reset or flush.
REQ-025 SHALL drive out_addr/out_instr to the (stale) head slot when out_valid is 0; consumers SHALL ignore them.

Reset
REQ-026 SHALL, while reset is high at a clock edge, set count = 0, read pointer = 0, write pointer = 0.
REQ-027 SHALL produce, in the cycle after reset: count = 0, out_valid = 0, in_ready = 1 (if flush low).
REQ-028 SHALL discard any push or pop requested in a cycle where reset is high.
REQ-029 SHALL, when reset is asserted mid-operation with entries stored, lose all entries; none SHALL reappear after reset.

Configuration
REQ-030 SHALL support macro FETCH_QUEUE_BYPASS_EN, tested with `ifdef.
REQ-031 SHALL, with FETCH_QUEUE_BYPASS_EN defined, when count == 0 and !flush, drive out_valid = in_valid, out_addr = in_addr, out_instr = in_instr combinationally; if out_ready is also high the entry SHALL be consumed without being stored (count stays 0), else it SHALL be stored normally.
REQ-032 SHALL, without FETCH_QUEUE_BYPASS_EN, behave per REQ-017/REQ-018 with no combinational in-to-out path.

Verification
REQ-033 Reset, then push addr 0x0/0x4/0x8/0xC (instr 0x11..0x14) with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> outputs 0x0,0x4,0x8,0xC in order, count back to 0.
REQ-034 Full queue, in_valid=1 and out_ready=1 same cycle -> pop only, count 4->3, pushed entry not accepted (in_ready was 0).
REQ-035 count=2, simultaneous push 0x20 and pop -> count stays 2; 0x20 appears after existing entries; repeat 10 times to exercise pointer wrap with no loss or reorder.
REQ-036 count=3, flush=1 with in_valid=1, out_ready=1 -> in_ready=0, out_valid=0 that cycle; next cycle count=0, out_valid=0.
REQ-037 count=2, reset=1 with push pending -> next cycle count=0, out_valid=0, in_ready=1; old entries never appear.
REQ-038 FETCH_QUEUE_BYPASS_EN defined, empty, in_valid=1 addr 0x40, out_ready=1 -> out_valid=1, out_addr=0x40 same cycle, count stays 0; undefined -> out_valid=0 that cycle, out_addr=0x40 next cycle.
